// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - three-byte command framer driving the 8-bit ALU tile and returning its result
// Optional result self-check enabled by defining ALU_CMD_SEQ_CHECK_EN.
module alu_cmd_sequencer #(
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_result,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] frame_cnt,
   output logic       chk_err
);

   typedef enum logic [2:0] {
      HDR,
      GET_A,
      GET_B,
      WAIT,
      HOLD
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [2:0] wait_cnt;
   logic       in_xfer;
   logic       out_xfer;
   logic       capture;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HDR;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      capture  = 1'b0;
      out_xfer = 1'b0;
      case (state)
         HDR: begin
            in_ready = !rst;
            if (in_valid && !rst) state_nx = GET_A;
         end
         GET_A: begin
            in_ready = !rst;
            if (in_valid && !rst) state_nx = GET_B;
         end
         GET_B: begin
            in_ready = !rst;
            if (in_valid && !rst) state_nx = WAIT;
         end
         WAIT: begin
            if (wait_cnt == 3'd0) begin
               capture  = 1'b1;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            // in_ready stays low here so a header can never share the result-transfer cycle
            out_xfer = out_ready;
            if (out_ready) state_nx = HDR;
         end
         default: state_nx = HDR;
      endcase
   end

   assign in_xfer = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a     <= 8'd0;
         alu_b     <= 8'd0;
         alu_op    <= 3'd0;
         wait_cnt  <= 3'd0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         if (in_xfer && state == HDR) alu_op <= in_data[7:5];
         if (in_xfer && state == GET_A) alu_a <= in_data;
         if (in_xfer && state == GET_B) begin
            alu_b    <= in_data;
            wait_cnt <= 3'(ALU_LAT - 1);
         end
         if (state == WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
         if (capture) begin
            out_data  <= alu_result;
            out_valid <= 1'b1;
         end
         if (out_xfer) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

`ifdef ALU_CMD_SEQ_CHECK_EN
   logic [7:0] model_result;
   logic       chk_err_q;

   always_comb begin
      model_result = 8'd0;
      case (alu_op)
         3'd0: model_result = alu_a + alu_b;
         3'd1: model_result = alu_a - alu_b;
         3'd2: model_result = alu_a & alu_b;
         3'd3: model_result = alu_a | alu_b;
         3'd4: model_result = alu_a ^ alu_b;
         3'd5: model_result = ~(alu_a & alu_b);
         3'd6: model_result = ~(alu_a | alu_b);
         default: model_result = ~alu_a;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_err_q <= 1'b0;
      end else if (capture && alu_result != model_result) begin
         chk_err_q <= 1'b1;
      end
   end

   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule
